// File: rtl/sdram_stream_writer.sv
// rtl/sdram_stream_writer.sv - packs a word stream into fixed-length SDRAM write bursts
// Define SDRAM_STREAM_WRITER_FLUSH_EN to pad and emit a frame's trailing partial burst instead of dropping it.
module sdram_stream_writer #(
  parameter int ADDR_WIDTH   = 24,
  parameter int DATA_WIDTH   = 16,
  parameter int BURST_LENGTH = 8
) (
  input  logic                  clk_axi,
  input  logic                  rstn_axi,
  input  logic                  enable_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  writer_valid,
  input  logic                  writer_ready,
  output logic [ADDR_WIDTH-1:0] writer_addr,
  output logic [DATA_WIDTH-1:0] writer_data,
  output logic [1:0]            writer_dqm_o,
  output logic                  frame_done_o,
  output logic                  align_err_o
);

  localparam int CW = $clog2(BURST_LENGTH);

  typedef enum logic [1:0] {FILL, ISSUE_ADDR, SEND_DATA} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] burst_buf [BURST_LENGTH];
  logic [CW:0]           fill_cnt;
  logic [CW-1:0]         beat_cnt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  frame_start;
  logic                  last_seen;
  logic                  armed;
  logic                  accept;
  logic                  beat_used;
  logic                  fill_last;
  logic                  beat_last;

  // armed keeps s_ready low while reset is held and for the first edge after release.
  assign s_ready      = armed && enable_i && (state == FILL);
  assign accept       = s_valid && s_ready;
  assign writer_valid = (state != FILL);
  assign beat_used    = ({1'b0, beat_cnt} < fill_cnt);
  assign fill_last    = (fill_cnt == (CW+1)'(BURST_LENGTH - 1));
  assign beat_last    = (beat_cnt == CW'(BURST_LENGTH - 1));

  assign writer_addr  = (state == ISSUE_ADDR) ? cur_addr : '0;
  assign writer_data  = (state == SEND_DATA && beat_used) ? burst_buf[beat_cnt] : '0;
  assign writer_dqm_o = (state == SEND_DATA && !beat_used) ? 2'b11 : 2'b00;

  always_ff @(posedge clk_axi) begin
    if (accept) begin
      burst_buf[fill_cnt[CW-1:0]] <= s_data;
    end
  end

  always_ff @(posedge clk_axi or negedge rstn_axi) begin
    if (!rstn_axi) begin
      state        <= FILL;
      fill_cnt     <= '0;
      beat_cnt     <= '0;
      cur_addr     <= '0;
      frame_start  <= 1'b1;
      last_seen    <= 1'b0;
      armed        <= 1'b0;
      frame_done_o <= 1'b0;
      align_err_o  <= 1'b0;
    end else begin
      armed        <= 1'b1;
      frame_done_o <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (frame_start) begin
              cur_addr    <= base_addr_i;
              frame_start <= 1'b0;
            end
            last_seen <= s_last;
            if (fill_last) begin
              fill_cnt <= fill_cnt + 1'b1;
              state    <= ISSUE_ADDR;
            end else if (s_last) begin
`ifdef SDRAM_STREAM_WRITER_FLUSH_EN
              fill_cnt <= fill_cnt + 1'b1;
              state    <= ISSUE_ADDR;
`else
              // Fragment is discarded; the frame still reports completion.
              fill_cnt     <= '0;
              frame_start  <= 1'b1;
              last_seen    <= 1'b0;
              align_err_o  <= 1'b1;
              frame_done_o <= 1'b1;
`endif
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        ISSUE_ADDR: begin
          if (writer_ready) begin
            state    <= SEND_DATA;
            beat_cnt <= '0;
          end
        end
        SEND_DATA: begin
          if (writer_ready) begin
            if (beat_last) begin
              state    <= FILL;
              fill_cnt <= '0;
              beat_cnt <= '0;
              cur_addr <= cur_addr + ADDR_WIDTH'(BURST_LENGTH);
              if (last_seen) begin
                frame_done_o <= 1'b1;
                frame_start  <= 1'b1;
                last_seen    <= 1'b0;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_stream_writer.sv
// tb/tb_sdram_stream_writer.sv - directed bench for sdram_stream_writer
module tb_sdram_stream_writer;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BL = 8;

  logic          clk_axi = 1'b0;
  logic          rstn_axi = 1'b0;
  logic          enable_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          writer_valid;
  logic          writer_ready = 1'b0;
  logic [AW-1:0] writer_addr;
  logic [DW-1:0] writer_data;
  logic [1:0]    writer_dqm_o;
  logic          frame_done_o;
  logic          align_err_o;

  sdram_stream_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH(BL)) dut (
    .clk_axi(clk_axi), .rstn_axi(rstn_axi), .enable_i(enable_i), .base_addr_i(base_addr_i),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .writer_valid(writer_valid), .writer_ready(writer_ready), .writer_addr(writer_addr),
    .writer_data(writer_data), .writer_dqm_o(writer_dqm_o), .frame_done_o(frame_done_o),
    .align_err_o(align_err_o)
  );

  always #5 clk_axi = ~clk_axi;

  int pass_cnt = 0;
  int total_cnt = 0;
  int to_err = 0;
  int ready_mode = 1;

  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  logic [1:0]    got_dqm[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  logic [1:0]    exp_dqm[$];
  int done_cnt = 0;
  int stall_err = 0;
  int drain_err = 0;
  int phase = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  logic [1:0]    prev_dqm = '0;

  always @(posedge clk_axi) begin
    #1;
    if (ready_mode == 2) writer_ready = 1'($urandom_range(0, 1));
    else writer_ready = (ready_mode == 1);
  end

  // Beat monitor: one address beat then BL data beats per burst.
  always @(negedge clk_axi) begin
    if (!rstn_axi) begin
      prev_stall = 1'b0;
      phase = 0;
    end else begin
      if (prev_stall && (!writer_valid || writer_addr !== prev_addr ||
                         writer_data !== prev_data || writer_dqm_o !== prev_dqm))
        stall_err++;
      if (writer_valid && s_ready) drain_err++;
      if (frame_done_o) done_cnt++;
      if (writer_valid && writer_ready) begin
        if (phase == 0) got_addr.push_back(writer_addr);
        else begin
          got_data.push_back(writer_data);
          got_dqm.push_back(writer_dqm_o);
        end
        phase = (phase == BL) ? 0 : phase + 1;
      end
      prev_stall = writer_valid && !writer_ready;
      prev_addr = writer_addr;
      prev_data = writer_data;
      prev_dqm = writer_dqm_o;
    end
  end

  task automatic clear_all();
    got_addr.delete(); got_data.delete(); got_dqm.delete();
    exp_addr.delete(); exp_data.delete(); exp_dqm.delete();
    done_cnt = 0; stall_err = 0; drain_err = 0; to_err = 0;
  endtask

  task automatic add_burst(input logic [AW-1:0] a, input logic [DW-1:0] first, input int used);
    exp_addr.push_back(a);
    for (int b = 0; b < BL; b++) begin
      if (b < used) begin
        exp_data.push_back(first + DW'(b));
        exp_dqm.push_back(2'b00);
      end else begin
        exp_data.push_back('0);
        exp_dqm.push_back(2'b11);
      end
    end
  endtask

  function automatic int count_bad();
    int bad = 0;
    if (got_addr.size() != exp_addr.size()) bad++;
    if (got_data.size() != exp_data.size()) bad++;
    foreach (exp_addr[i]) if (i >= got_addr.size() || got_addr[i] !== exp_addr[i]) bad++;
    foreach (exp_data[i])
      if (i >= got_data.size() || got_data[i] !== exp_data[i] || got_dqm[i] !== exp_dqm[i]) bad++;
    return bad;
  endfunction

  task automatic push_word(input logic [DW-1:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    @(negedge clk_axi);
    while (!s_ready && n < 500) begin
      @(negedge clk_axi);
      n++;
    end
    if (!s_ready) to_err++;
    @(posedge clk_axi); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic push_frame(input logic [AW-1:0] base, input logic [DW-1:0] first, input int n);
    base_addr_i = base;
    for (int i = 0; i < n; i++) push_word(first + DW'(i), i == n - 1);
  endtask

  task automatic wait_drain(input int na, input int nd);
    int n = 0;
    while ((got_addr.size() < na || got_data.size() < nd) && n < 500) begin
      @(negedge clk_axi);
      n++;
    end
    if (n >= 500) to_err++;
    repeat (4) @(posedge clk_axi);
    #1;
  endtask

  task automatic test_reset();
    enable_i = 1'b1;
    rstn_axi = 1'b0;
    repeat (3) @(negedge clk_axi);
    total_cnt += 7;
    if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready); else pass_cnt++;
    if (writer_valid !== 1'b0) $display("FAIL reset_writer_valid: got %b want 0", writer_valid); else pass_cnt++;
    if (writer_addr !== '0) $display("FAIL reset_writer_addr: got %h want 0", writer_addr); else pass_cnt++;
    if (writer_data !== '0) $display("FAIL reset_writer_data: got %h want 0", writer_data); else pass_cnt++;
    if (writer_dqm_o !== 2'b00) $display("FAIL reset_dqm: got %b want 00", writer_dqm_o); else pass_cnt++;
    if (frame_done_o !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done_o); else pass_cnt++;
    if (align_err_o !== 1'b0) $display("FAIL reset_align_err: got %b want 0", align_err_o); else pass_cnt++;
    @(posedge clk_axi); #1;
    rstn_axi = 1'b1;
    repeat (2) @(posedge clk_axi);
    #1;
    total_cnt += 2;
    if (s_ready !== 1'b1) $display("FAIL post_reset_s_ready: got %b want 1", s_ready); else pass_cnt++;
    if (writer_valid !== 1'b0) $display("FAIL post_reset_writer_valid: got %b want 0", writer_valid); else pass_cnt++;
  endtask

  task automatic test_basic();
    int n = 0;
    clear_all();
    ready_mode = 1;
    base_addr_i = 24'h000100;
    for (int i = 0; i < 8; i++) push_word(DW'(i + 1), 1'b0);
    total_cnt += 3;
    if (writer_valid !== 1'b1) $display("FAIL basic_addr_latency: writer_valid %b want 1", writer_valid); else pass_cnt++;
    if (writer_addr !== 24'h000100) $display("FAIL basic_addr_beat: got %h want 000100", writer_addr); else pass_cnt++;
    if (s_ready !== 1'b0) $display("FAIL basic_s_ready_drain: got %b want 0", s_ready); else pass_cnt++;
    do begin
      @(posedge clk_axi); #1;
      n++;
    end while (!s_ready && n < 50);
    total_cnt++;
    if (n !== BL + 1) $display("FAIL basic_refill_latency: got %0d edges want %0d", n, BL + 1); else pass_cnt++;
    for (int i = 8; i < 16; i++) push_word(DW'(i + 1), i == 15);
    wait_drain(2, 16);
    add_burst(24'h000100, 16'h0001, BL);
    add_burst(24'h000108, 16'h0009, BL);
    total_cnt += 5;
    if (count_bad() !== 0) $display("FAIL basic_beats: %0d bad beats want 0", count_bad()); else pass_cnt++;
    if (done_cnt !== 1) $display("FAIL basic_frame_done: got %0d pulses want 1", done_cnt); else pass_cnt++;
    if (align_err_o !== 1'b0) $display("FAIL basic_align_err: got %b want 0", align_err_o); else pass_cnt++;
    if (drain_err !== 0) $display("FAIL basic_s_ready_overlap: got %0d want 0", drain_err); else pass_cnt++;
    if (to_err !== 0) $display("FAIL basic_timeout: got %0d want 0", to_err); else pass_cnt++;
  endtask

  task automatic test_restart();
    clear_all();
    push_frame(24'h000400, 16'h0020, 8);
    wait_drain(1, 8);
    add_burst(24'h000400, 16'h0020, BL);
    total_cnt += 3;
    if (count_bad() !== 0) $display("FAIL restart_beats: %0d bad beats want 0", count_bad()); else pass_cnt++;
    if (done_cnt !== 1) $display("FAIL restart_frame_done: got %0d want 1", done_cnt); else pass_cnt++;
    if (to_err !== 0) $display("FAIL restart_timeout: got %0d want 0", to_err); else pass_cnt++;
  endtask

  task automatic test_stall();
    clear_all();
    ready_mode = 2;
    push_frame(24'h000100, 16'h0001, 16);
    wait_drain(2, 16);
    ready_mode = 1;
    add_burst(24'h000100, 16'h0001, BL);
    add_burst(24'h000108, 16'h0009, BL);
    total_cnt += 5;
    if (count_bad() !== 0) $display("FAIL stall_beats: %0d bad beats want 0", count_bad()); else pass_cnt++;
    if (stall_err !== 0) $display("FAIL stall_stability: %0d unstable cycles want 0", stall_err); else pass_cnt++;
    if (drain_err !== 0) $display("FAIL stall_s_ready_drain: got %0d want 0", drain_err); else pass_cnt++;
    if (done_cnt !== 1) $display("FAIL stall_frame_done: got %0d want 1", done_cnt); else pass_cnt++;
    if (to_err !== 0) $display("FAIL stall_timeout: got %0d want 0", to_err); else pass_cnt++;
  endtask

  task automatic test_wrap();
    clear_all();
    push_frame(24'hFFFFF8, 16'h0031, 16);
    wait_drain(2, 16);
    add_burst(24'hFFFFF8, 16'h0031, BL);
    add_burst(24'h000000, 16'h0039, BL);
    total_cnt += 3;
    if (count_bad() !== 0) $display("FAIL wrap_beats: %0d bad beats want 0", count_bad()); else pass_cnt++;
    if (got_addr.size() > 1 && got_addr[1] !== 24'h000000)
      $display("FAIL wrap_addr: got %h want 000000", got_addr[1]);
    if (done_cnt !== 1) $display("FAIL wrap_frame_done: got %0d want 1", done_cnt); else pass_cnt++;
    if (to_err !== 0) $display("FAIL wrap_timeout: got %0d want 0", to_err); else pass_cnt++;
  endtask

  task automatic test_enable();
    int bad = 0;
    clear_all();
    base_addr_i = 24'h000300;
    for (int i = 0; i < 3; i++) push_word(DW'(16'h0051 + i), 1'b0);
    enable_i = 1'b0;
    s_valid = 1'b1; s_data = 16'h0054;
    repeat (20) begin
      @(negedge clk_axi);
      if (s_ready || writer_valid) bad++;
    end
    @(posedge clk_axi); #1;
    enable_i = 1'b1;
    for (int i = 3; i < 8; i++) push_word(DW'(16'h0051 + i), i == 7);
    wait_drain(1, 8);
    add_burst(24'h000300, 16'h0051, BL);
    total_cnt += 4;
    if (bad !== 0) $display("FAIL enable_hold: %0d active cycles while disabled want 0", bad); else pass_cnt++;
    if (count_bad() !== 0) $display("FAIL enable_beats: %0d bad beats want 0", count_bad()); else pass_cnt++;
    if (done_cnt !== 1) $display("FAIL enable_frame_done: got %0d want 1", done_cnt); else pass_cnt++;
    if (to_err !== 0) $display("FAIL enable_timeout: got %0d want 0", to_err); else pass_cnt++;
  endtask

  task automatic test_align();
    clear_all();
    push_frame(24'h000100, 16'h0001, 11);
    add_burst(24'h000100, 16'h0001, BL);
`ifdef SDRAM_STREAM_WRITER_FLUSH_EN
    add_burst(24'h000108, 16'h0009, 3);
    wait_drain(2, 16);
    total_cnt++;
    if (align_err_o !== 1'b0) $display("FAIL align_err_flush: got %b want 0", align_err_o); else pass_cnt++;
`else
    wait_drain(1, 8);
    repeat (10) @(posedge clk_axi);
    #1;
    total_cnt++;
    if (align_err_o !== 1'b1) $display("FAIL align_err_drop: got %b want 1", align_err_o); else pass_cnt++;
`endif
    total_cnt += 3;
    if (count_bad() !== 0) $display("FAIL align_beats: %0d bad beats want 0", count_bad()); else pass_cnt++;
    if (done_cnt !== 1) $display("FAIL align_frame_done: got %0d want 1", done_cnt); else pass_cnt++;
    if (to_err !== 0) $display("FAIL align_timeout: got %0d want 0", to_err); else pass_cnt++;
  endtask

  task automatic test_midreset();
    int n = 0;
    clear_all();
    base_addr_i = 24'h000500;
    for (int i = 0; i < 8; i++) push_word(DW'(16'h0061 + i), 1'b0);
    while (got_data.size() < 5 && n < 100) begin
      @(negedge clk_axi); #1;
      n++;
    end
    rstn_axi = 1'b0;
    #1;
    total_cnt += 3;
    if (n >= 100) $display("FAIL midreset_reach_beat4: got %0d beats want 5", got_data.size()); else pass_cnt++;
    if (writer_valid !== 1'b0) $display("FAIL midreset_writer_valid: got %b want 0", writer_valid); else pass_cnt++;
    if (s_ready !== 1'b0) $display("FAIL midreset_s_ready: got %b want 0", s_ready); else pass_cnt++;
    repeat (2) @(posedge clk_axi);
    #1;
    rstn_axi = 1'b1;
    clear_all();
    push_frame(24'h000700, 16'h0071, 8);
    wait_drain(1, 8);
    add_burst(24'h000700, 16'h0071, BL);
    total_cnt += 4;
    if (count_bad() !== 0) $display("FAIL midreset_beats: %0d bad beats want 0", count_bad()); else pass_cnt++;
    if (align_err_o !== 1'b0) $display("FAIL midreset_align_err: got %b want 0", align_err_o); else pass_cnt++;
    if (done_cnt !== 1) $display("FAIL midreset_frame_done: got %0d want 1", done_cnt); else pass_cnt++;
    if (to_err !== 0) $display("FAIL midreset_timeout: got %0d want 0", to_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_stall();
    test_wrap();
    test_enable();
    test_align();
    test_midreset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sdram_stream_writer.md
# sdram_stream_writer

Burst-packing stage directly upstream of the SDRAM driver's writer port, in the AXI clock domain. Accepts a video/data word stream with end-of-frame marker, collects words into a local BURST_LENGTH-deep buffer, then emits one address beat followed by exactly BURST_LENGTH data beats (with per-beat DQM) on the driver's writer handshake. Tracks the linear SDRAM word address per frame, restarting at a programmable base on each frame boundary.

## Interface
- ADDR_WIDTH, 24, SDRAM word address width
- DATA_WIDTH, 16, data word width
- BURST_LENGTH, 8, words per SDRAM write burst (power of two, ≥2)
- clk_axi  in  1  clock
- rstn_axi  in  1  reset, asynchronous, active-low
- enable_i  in  1  allows FILL to accept stream words
- base_addr_i  in  ADDR_WIDTH  frame start word address, sampled at first word of each frame
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when s_valid && s_ready
- s_data  in  DATA_WIDTH  stream word
- s_last  in  1  last word of frame
- writer_valid  out  1  beat valid toward driver
- writer_ready  in  1  driver accepts beat
- writer_addr  out  ADDR_WIDTH  burst start address (meaningful on address beat)
- writer_data  out  DATA_WIDTH  burst data (meaningful on data beats)
- writer_dqm_o  out  2  per-beat byte mask, 2'b00 = write, 2'b11 = masked
- frame_done_o  out  1  one-cycle pulse when final burst of a frame completes
- align_err_o  out  1  sticky: frame ended on non-burst boundary (cleared only by reset)

## Operation
- States: FILL, ISSUE_ADDR, SEND_DATA. Reset → FILL, fill_cnt=0, beat_cnt=0, cur_addr=0, frame_start=1, last_seen=0.
- FILL: s_ready = enable_i. On accept: buf[fill_cnt]=s_data, fill_cnt++; if frame_start, cur_addr←base_addr_i, frame_start←0. last_seen←s_last.
  - fill_cnt reaches BURST_LENGTH (accept with fill_cnt==BURST_LENGTH-1) → ISSUE_ADDR.
  - s_last accepted with fill_cnt<BURST_LENGTH-1: see Configuration.
- ISSUE_ADDR: writer_valid=1, writer_addr=cur_addr, s_ready=0. On writer_ready → SEND_DATA, beat_cnt=0.
- SEND_DATA: writer_valid=1, writer_data=buf[beat_cnt], writer_dqm_o = (beat_cnt<fill_cnt) ? 2'b00 : 2'b11. On handshake beat_cnt++. Handshake with beat_cnt==BURST_LENGTH-1 → FILL, fill_cnt=0, cur_addr += BURST_LENGTH (mod 2^ADDR_WIDTH); if last_seen: frame_done_o pulse next cycle, frame_start←1, last_seen←0.
- writer_addr/writer_data/writer_dqm_o are don't-care outside their beats; drive 0 in FILL.
- enable_i deasserted affects only FILL acceptance; an in-progress ISSUE_ADDR/SEND_DATA completes. Buffered partial words are retained.
- writer_valid never drops once asserted until handshake (AXI-style stability); writer_addr/data/dqm stable while writer_valid && !writer_ready.
- Reset mid-burst: all state cleared immediately; partial burst discarded; no completion of emitted address beat (driver is reset with same reset).

## Timing
- Reset values: s_ready=0 during reset, then enable_i; writer_valid=0, writer_addr=0, writer_data=0, writer_dqm_o=0, frame_done_o=0, align_err_o=0.
- s_ready and writer_valid are decodes of registered state (no combinational path writer_ready→s_ready).
- Word accepted completing burst at cycle N → address beat valid at N+1. With writer_ready held 1: address beat N+1, data beats N+2..N+BURST_LENGTH+1, s_ready back high at N+BURST_LENGTH+2.
- Peak throughput: BURST_LENGTH words per 2·BURST_LENGTH+1 cycles (single buffer; no fill during drain).
- frame_done_o asserted exactly one cycle, the cycle after the last data handshake of the frame.

## Configuration
- Macro SDRAM_STREAM_WRITER_FLUSH_EN.
- Defined: s_last accepted with a partial burst → ISSUE_ADDR immediately; unfilled beats sent with writer_dqm_o=2'b11 (data 0); align_err_o never set.
- Undefined: s_last accepted with a partial burst → partial words dropped, fill_cnt=0, frame_start←1, align_err_o←1, frame_done_o pulses next cycle; no writer traffic for that fragment. Full-burst frame ends behave identically in both builds.

## Test plan
- Base 0x000100, 16 words 0x0001..0x0010, last on word 16, writer_ready=1 → two bursts: addr 0x000100 data 0x0001..0x0008, addr 0x000108 data 0x0009..0x0010, all dqm 2'b00; one frame_done_o pulse; second frame restarts at base.
- Same as above with writer_ready toggling 1/0 random → identical beat sequence, outputs stable during stalls, s_ready=0 throughout drain.
- Frame of 11 words, FLUSH_EN defined → second burst addr 0x000108, beats 0..2 dqm 2'b00, beats 3..7 dqm 2'b11; align_err_o=0. Undefined → only first burst emitted, align_err_o=1, frame_done_o pulses.
- cur_addr at 0xFFFFF8, 16-word frame with base 0xFFFFF8 → bursts at 0xFFFFF8 then 0x000000.
- enable_i dropped after 3 words, held low 20 cycles → s_ready=0, no writer_valid; resumes and burst contains the 8 words in order.
- rstn_axi asserted during SEND_DATA beat 4 → writer_valid=0 immediately; after release next frame first burst at new base_addr_i, no stale data.
